// File: rtl/hazard_unit_if.sv
// Decode/execute-side signal bundle for hazard_unit: decode operands and controls in,
// stall/flush/forwarding controls and event counters out.
interface hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16,
  parameter int FW     = 2
);
  logic              de_valid;
  logic [REG_AW-1:0] de_rs1, de_rs2, de_rd;
  logic              de_use_rs1, de_use_rs2;
  logic              de_RegWrite, de_MemRead, de_MemWrite;
  logic              ex_branch_taken;
  logic              mem_done;

  logic              stall_if, stall_de, flush_if, flush_de, pc_load, stall_mem;
  logic [FW-1:0]     fwd_rs1, fwd_rs2;
  logic              rb_bypass_rs1, rb_bypass_rs2;
  logic [CNT_W-1:0]  stall_count, flush_count;

  modport master (
    output de_valid, de_rs1, de_rs2, de_rd, de_use_rs1, de_use_rs2,
           de_RegWrite, de_MemRead, de_MemWrite, ex_branch_taken, mem_done,
    input  stall_if, stall_de, flush_if, flush_de, pc_load, stall_mem,
           fwd_rs1, fwd_rs2, rb_bypass_rs1, rb_bypass_rs2, stall_count, flush_count
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2, de_rd, de_use_rs1, de_use_rs2,
           de_RegWrite, de_MemRead, de_MemWrite, ex_branch_taken, mem_done,
    output stall_if, stall_de, flush_if, flush_de, pc_load, stall_mem,
           fwd_rs1, fwd_rs2, rb_bypass_rs1, rb_bypass_rs2, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: shadow scoreboard of post-decode stages driving
// stall/flush/bubble controls, EX forwarding selects, WB->decode bypass and event counters.
module hazard_unit #(
  parameter int STAGES    = 3,
  parameter int MEM_STAGE = 1,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter int FW        = $clog2(STAGES)
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_unit_if.slave hif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic              use1, use2, rw, mr, mw;
  } entry_t;

  entry_t [STAGES-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                mem_stall, branch, lu_hit, load_use, stall;

  function automatic logic producer(input entry_t e);
    return e.valid && e.rw && (e.rd != '0);
  endfunction

  // Loop runs oldest-to-youngest so the youngest qualifying stage wins.
  function automatic logic [FW-1:0] fwd_sel(input entry_t [STAGES-1:0] sb,
                                             input logic [REG_AW-1:0] rs, input logic use_);
    fwd_sel = '0;
    if (sb[0].valid && use_)
      for (int k = STAGES-1; k >= 1; k--)
        if (producer(sb[k]) && sb[k].rd == rs && (!sb[k].mr || k > MEM_STAGE))
          fwd_sel = FW'(k);
  endfunction

  always_comb begin
    lu_hit = 1'b0;
    for (int j = 0; j < MEM_STAGE; j++)
      if (sb_q[j].valid && sb_q[j].mr && sb_q[j].rd != '0 &&
          ((hif.de_use_rs1 && sb_q[j].rd == hif.de_rs1) ||
           (hif.de_use_rs2 && sb_q[j].rd == hif.de_rs2)))
        lu_hit = 1'b1;
  end

  assign mem_stall = sb_q[MEM_STAGE].valid && (sb_q[MEM_STAGE].mr || sb_q[MEM_STAGE].mw) &&
                     !hif.mem_done;
  assign branch    = hif.ex_branch_taken && sb_q[0].valid && !mem_stall;
  assign load_use  = lu_hit && !mem_stall && !branch;
  assign stall     = mem_stall || load_use;

  assign hif.stall_mem     = mem_stall;
  assign hif.stall_if      = stall;
  assign hif.stall_de      = stall;
  assign hif.flush_if      = branch;
  assign hif.flush_de      = branch;
  assign hif.pc_load       = branch;
  assign hif.fwd_rs1       = fwd_sel(sb_q, sb_q[0].rs1, sb_q[0].use1);
  assign hif.fwd_rs2       = fwd_sel(sb_q, sb_q[0].rs2, sb_q[0].use2);
  assign hif.rb_bypass_rs1 = producer(sb_q[STAGES-1]) && sb_q[STAGES-1].rd == hif.de_rs1 &&
                             hif.de_use_rs1 && hif.de_rs1 != '0;
  assign hif.rb_bypass_rs2 = producer(sb_q[STAGES-1]) && sb_q[STAGES-1].rd == hif.de_rs2 &&
                             hif.de_use_rs2 && hif.de_rs2 != '0;
  assign hif.stall_count   = stall_cnt_q;
  assign hif.flush_count   = flush_cnt_q;

  always_comb begin
    sb_d = sb_q;
    if (mem_stall) begin
      // Stages up to the memory stage freeze; the slot just behind it opens a bubble.
      for (int i = MEM_STAGE + 2; i < STAGES; i++) sb_d[i] = sb_q[i-1];
      sb_d[MEM_STAGE+1] = '0;
    end else begin
      for (int i = 1; i < STAGES; i++) sb_d[i] = sb_q[i-1];
      if (branch || load_use) begin
        sb_d[0] = '0;
      end else begin
        sb_d[0].valid = hif.de_valid;
        sb_d[0].rd    = hif.de_rd;
        sb_d[0].rs1   = hif.de_rs1;
        sb_d[0].rs2   = hif.de_rs2;
        sb_d[0].use1  = hif.de_use_rs1;
        sb_d[0].use2  = hif.de_use_rs2;
        sb_d[0].rw    = hif.de_RegWrite;
        sb_d[0].mr    = hif.de_MemRead;
        sb_d[0].mw    = hif.de_MemWrite;
      end
    end
  end

  assign stall_cnt_d = (stall  && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign flush_cnt_d = (branch && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Two hazard_unit configurations (3/1/16 and 5/2/2) driven with identical directed and
// random decode streams, each checked against an instruction-level pipeline model.
module tb_hazard_unit;

  typedef struct { bit v; int rd, rs1, rs2; bit u1, u2, rw, mr, mw; } ent_t;
  typedef struct { bit dv; int rd, rs1, rs2; bit u1, u2, rw, mr, mw, br, done; } in_t;
  typedef struct { logic [31:0] sif, sde, fif, fde, pcl, smem, f1, f2, b1, b2, sc, fc; } out_t;

  logic clk, rst_n;
  int   checks = 0, errors = 0;

  hazard_unit_if #(.REG_AW(5), .CNT_W(16), .FW(2)) if0 ();
  hazard_unit_if #(.REG_AW(5), .CNT_W(2),  .FW(3)) if1 ();

  hazard_unit #(.STAGES(3), .MEM_STAGE(1), .REG_AW(5), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .hif(if0));
  hazard_unit #(.STAGES(5), .MEM_STAGE(2), .REG_AW(5), .CNT_W(2))  u1 (.clk(clk), .rst_n(rst_n), .hif(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the in-flight instructions of each pipeline, youngest first.
  int   ST[2]   = '{3, 5};
  int   MS[2]   = '{1, 2};
  int   CMAX[2] = '{65535, 3};
  ent_t sb[2][8];
  int   sc[2], fc[2];
  out_t o0, o1;

  function automatic ent_t bubble();
    ent_t e = '{default: 0};
    return e;
  endfunction

  function automatic void mreset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 8; i++) sb[u][i] = bubble();
      sc[u] = 0; fc[u] = 0;
    end
  endfunction

  function automatic int src(int u, int rs, bit use_);
    if (!sb[u][0].v || !use_) return 0;
    for (int k = 1; k < ST[u]; k++) begin
      ent_t e = sb[u][k];
      if (e.v && e.rw && e.rd != 0 && e.rd == rs && (!e.mr || k > MS[u])) return k;
    end
    return 0;
  endfunction

  function automatic out_t mexp(int u, in_t x);
    out_t o;
    ent_t m, last;
    bit   ms, br, lu;
    m    = sb[u][MS[u]];
    last = sb[u][ST[u]-1];
    ms   = m.v && (m.mr || m.mw) && !x.done;
    br   = x.br && sb[u][0].v && !ms;
    lu   = 0;
    for (int j = 0; j < MS[u]; j++) begin
      ent_t e = sb[u][j];
      if (e.v && e.mr && e.rd != 0 && ((x.u1 && e.rd == x.rs1) || (x.u2 && e.rd == x.rs2))) lu = 1;
    end
    lu     = lu && !ms && !br;
    o.smem = 32'(ms);
    o.sif  = 32'(ms || lu);
    o.sde  = 32'(ms || lu);
    o.fif  = 32'(br);
    o.fde  = 32'(br);
    o.pcl  = 32'(br);
    o.f1   = src(u, sb[u][0].rs1, sb[u][0].u1);
    o.f2   = src(u, sb[u][0].rs2, sb[u][0].u2);
    o.b1   = 32'(last.v && last.rw && last.rd == x.rs1 && x.u1 && x.rs1 != 0);
    o.b2   = 32'(last.v && last.rw && last.rd == x.rs2 && x.u2 && x.rs2 != 0);
    o.sc   = sc[u];
    o.fc   = fc[u];
    return o;
  endfunction

  function automatic void madv(int u, in_t x, out_t o);
    ent_t d = '{v: x.dv, rd: x.rd, rs1: x.rs1, rs2: x.rs2,
                u1: x.u1, u2: x.u2, rw: x.rw, mr: x.mr, mw: x.mw};
    if (o.smem != 0) begin
      for (int i = ST[u]-1; i >= MS[u]+2; i--) sb[u][i] = sb[u][i-1];
      sb[u][MS[u]+1] = bubble();
    end else begin
      for (int i = ST[u]-1; i >= 1; i--) sb[u][i] = sb[u][i-1];
      sb[u][0] = (o.fde != 0 || o.sif != 0) ? bubble() : d;
    end
    if (o.sif != 0 && sc[u] < CMAX[u]) sc[u]++;
    if (o.fde != 0 && fc[u] < CMAX[u]) fc[u]++;
  endfunction

  function automatic out_t rd_dut(int u);
    out_t o;
    if (u == 0) begin
      o = '{if0.stall_if, if0.stall_de, if0.flush_if, if0.flush_de, if0.pc_load, if0.stall_mem,
            32'(if0.fwd_rs1), 32'(if0.fwd_rs2), if0.rb_bypass_rs1, if0.rb_bypass_rs2,
            32'(if0.stall_count), 32'(if0.flush_count)};
    end else begin
      o = '{if1.stall_if, if1.stall_de, if1.flush_if, if1.flush_de, if1.pc_load, if1.stall_mem,
            32'(if1.fwd_rs1), 32'(if1.fwd_rs2), if1.rb_bypass_rs1, if1.rb_bypass_rs2,
            32'(if1.stall_count), 32'(if1.flush_count)};
    end
    return o;
  endfunction

  task automatic chk(string tag, int u, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, u, obs, exp);
    end
  endtask

  task automatic cmp(int u, out_t o, out_t e);
    chk("stall_if", u, o.sif, e.sif);   chk("stall_de", u, o.sde, e.sde);
    chk("flush_if", u, o.fif, e.fif);   chk("flush_de", u, o.fde, e.fde);
    chk("pc_load", u, o.pcl, e.pcl);    chk("stall_mem", u, o.smem, e.smem);
    chk("fwd_rs1", u, o.f1, e.f1);      chk("fwd_rs2", u, o.f2, e.f2);
    chk("rb_bypass_rs1", u, o.b1, e.b1); chk("rb_bypass_rs2", u, o.b2, e.b2);
    chk("stall_count", u, o.sc, e.sc);  chk("flush_count", u, o.fc, e.fc);
  endtask

  task automatic drive(in_t x);
    if0.de_valid = x.dv; if0.de_rd = 5'(x.rd); if0.de_rs1 = 5'(x.rs1); if0.de_rs2 = 5'(x.rs2);
    if0.de_use_rs1 = x.u1; if0.de_use_rs2 = x.u2; if0.de_RegWrite = x.rw;
    if0.de_MemRead = x.mr; if0.de_MemWrite = x.mw; if0.ex_branch_taken = x.br; if0.mem_done = x.done;
    if1.de_valid = x.dv; if1.de_rd = 5'(x.rd); if1.de_rs1 = 5'(x.rs1); if1.de_rs2 = 5'(x.rs2);
    if1.de_use_rs1 = x.u1; if1.de_use_rs2 = x.u2; if1.de_RegWrite = x.rw;
    if1.de_MemRead = x.mr; if1.de_MemWrite = x.mw; if1.ex_branch_taken = x.br; if1.mem_done = x.done;
  endtask

  // One cycle: drive at the falling edge, compare mid-cycle, advance the model.
  task automatic step(in_t x);
    out_t e0, e1;
    @(negedge clk);
    drive(x);
    #1;
    e0 = mexp(0, x); e1 = mexp(1, x);
    o0 = rd_dut(0);  o1 = rd_dut(1);
    cmp(0, o0, e0);  cmp(1, o1, e1);
    madv(0, x, e0);  madv(1, x, e1);
  endtask

  function automatic in_t nop(bit done = 1);
    in_t x = '{default: 0};
    x.done = done;
    return x;
  endfunction

  function automatic in_t alu(int rd, int rs1, int rs2, bit br = 0);
    in_t x = '{dv: 1, rd: rd, rs1: rs1, rs2: rs2, u1: 1, u2: 1, rw: 1, mr: 0, mw: 0, br: br, done: 1};
    return x;
  endfunction

  function automatic in_t lw(int rd, int rs1);
    in_t x = '{dv: 1, rd: rd, rs1: rs1, rs2: 0, u1: 1, u2: 0, rw: 1, mr: 1, mw: 0, br: 0, done: 1};
    return x;
  endfunction

  function automatic in_t rnd();
    in_t x;
    x.dv = ($urandom_range(0, 3) != 0);
    x.rd = $urandom_range(0, 3);  x.rs1 = $urandom_range(0, 3); x.rs2 = $urandom_range(0, 3);
    x.u1 = 1'($urandom_range(0, 1)); x.u2 = 1'($urandom_range(0, 1));
    x.rw = ($urandom_range(0, 3) != 0);
    x.mr = ($urandom_range(0, 3) == 0);
    x.mw = !x.mr && ($urandom_range(0, 5) == 0);
    x.br = ($urandom_range(0, 6) == 0);
    x.done = ($urandom_range(0, 3) != 0);
    return x;
  endfunction

  initial begin
    int base;
    rst_n = 1'b0;
    mreset();
    drive(nop());
    #1;
    cmp(0, rd_dut(0), mexp(0, nop())); cmp(1, rd_dut(1), mexp(1, nop()));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(nop());

    // Back-to-back ALU ops forward from stage 1.
    step(alu(5, 1, 2));
    step(alu(6, 5, 3));
    step(nop());
    chk("alu_fwd_rs1", 0, o0.f1, 1);
    chk("alu_no_stall", 0, o0.sif, 0);

    // Load then use: one bubble, then forward from stage 2.
    step(lw(7, 1));
    step(alu(8, 7, 1));
    chk("lu_stall", 0, o0.sif, 1);
    step(alu(8, 7, 1));
    chk("lu_release", 0, o0.sif, 0);
    step(nop());
    chk("lu_fwd_rs1", 0, o0.f1, 2);
    chk("lu_stall_count", 0, o0.sc, 1);

    // Memory wait: three cycles of mem_done low.
    step(lw(10, 1));
    step(nop());
    base = int'(o0.sc);
    for (int i = 0; i < 3; i++) begin
      step(nop(0));
      chk("mem_wait_stall", 0, o0.smem, 1);
    end
    step(nop());
    chk("mem_wait_clear", 0, o0.smem, 0);
    chk("mem_wait_count", 0, o0.sc, 32'(base + 3));

    // Branch beats a simultaneous load-use hazard.
    step(lw(7, 1));
    base = int'(o0.fc);
    step(alu(8, 7, 1, 1));
    chk("br_flush_de", 0, o0.fde, 1);
    chk("br_pc_load", 0, o0.pcl, 1);
    chk("br_no_stall", 0, o0.sif, 0);
    step(nop());
    chk("br_one_cycle", 0, o0.fif, 0);
    chk("br_flush_count", 0, o0.fc, 32'(base + 1));

    // x0 is never a producer; WB feeds decode through the bypass.
    step(lw(0, 1));
    step(alu(8, 0, 0));
    chk("x0_no_stall", 0, o0.sif, 0);
    step(nop());
    chk("x0_no_fwd", 0, o0.f1, 0);
    step(alu(9, 1, 2));
    step(nop());
    step(nop());
    step(alu(11, 9, 3));
    chk("wb_bypass_rs1", 0, o0.b1, 1);

    // Deep configuration: two-cycle load-use, saturated counter, reset mid-stall.
    step(nop()); step(nop()); step(nop()); step(nop());
    step(lw(7, 1));
    step(alu(8, 7, 1));
    chk("deep_lu_c1", 1, o1.sif, 1);
    step(alu(8, 7, 1));
    chk("deep_lu_c2", 1, o1.sif, 1);
    step(alu(8, 7, 1));
    chk("deep_lu_done", 1, o1.sif, 0);
    chk("deep_sat_count", 1, o1.sc, 3);
    step(lw(12, 1));
    step(nop()); step(nop());
    step(nop(0));
    chk("deep_mem_stall", 1, o1.smem, 1);
    rst_n = 1'b0;
    #1;
    mreset();
    cmp(0, rd_dut(0), mexp(0, nop(0))); cmp(1, rd_dut(1), mexp(1, nop(0)));
    @(negedge clk);
    rst_n = 1'b1;
    step(nop(0));
    chk("post_reset_stall", 1, o1.smem, 0);

    repeat (400) step(rnd());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
